// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 constants: exception codes, CP0 register numbers and the EXL state encoding.
package cp0_exc_unit_pkg;

  localparam logic [4:0] EXC_NULL = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  typedef enum logic {
    NORMAL     = 1'b0,
    IN_HANDLER = 1'b1
  } state_t;

endpackage

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: SR/Cause/EPC/PRId, zero-latency Req, state updates on the next edge.
// Define CP0_BD_EN to record branch-delay-slot victims (EPC = VPC-4, Cause.BD).
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE = 32'h2020_0290
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  output logic [31:0] RD,
  input  logic [4:0]  A2,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC
);

  state_t      state;
  logic        exl;
  logic [5:0]  im;
  logic        ie;
  logic [5:0]  ip;
  logic [4:0]  exccode;
  logic        bd;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim_epc;
  logic        victim_bd;

  assign exl = (state == IN_HANDLER);

  assign int_req = ie & ~exl & (|(HWInt & im));
  assign exc_req = ~exl & (ExcCodeIn != EXC_NULL);
  assign Req     = ~reset & (int_req | exc_req);

`ifdef CP0_BD_EN
  assign victim_epc = BDIn ? (VPC - 32'd4) : VPC;
  assign victim_bd  = BDIn;
`else
  logic unused_bdin;
  assign unused_bdin = BDIn;
  assign victim_epc  = VPC;
  assign victim_bd   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= NORMAL;
      im      <= 6'd0;
      ie      <= 1'b0;
      ip      <= 6'd0;
      exccode <= 5'd0;
      bd      <= 1'b0;
      epc     <= 32'd0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        // An exception entry swallows any mtc0 issued in the same cycle.
        state   <= IN_HANDLER;
        exccode <= int_req ? EXC_INT : ExcCodeIn;
        bd      <= victim_bd;
        epc     <= victim_epc;
      end else begin
        if (WE && (A2 == CP0_SR)) begin
          im    <= WD[15:10];
          ie    <= WD[0];
          state <= WD[1] ? IN_HANDLER : NORMAL;
        end
        if (WE && (A2 == CP0_EPC)) begin
          epc <= {WD[31:2], 2'b00};
        end
        // eret wins over a simultaneous mtc0 to SR.
        if (EXLClr) begin
          state <= NORMAL;
        end
      end
    end
  end

  always_comb begin
    RD = 32'd0;
    case (A1)
      CP0_SR:    RD = {16'd0, im, 8'd0, exl, ie};
      CP0_CAUSE: RD = {bd, 15'd0, ip, 3'd0, exccode, 2'd0};
      CP0_EPC:   RD = epc;
      CP0_PRID:  RD = PRID_VALUE;
      default:   RD = 32'd0;
    endcase
  end

  assign EPCOut    = epc;
  assign HandlerPC = HANDLER_PC;

endmodule
